defuzz_wavg: RTL and testbench



---
 rtl/defuzz_wavg.sv | 181 ++++++++++++++++++
 tb/tb_defuzz_wavg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/defuzz_wavg.sv
// Sequential weighted-average (singleton centroid) defuzzifier: one shared multiplier, 35-step restoring divider.
// Optional build macro DEFUZZ_ROUND_EN selects round-half-away-from-zero instead of truncation.
module defuzz_wavg #(
    parameter logic signed [15:0] S_NN      = -16'sd16384,
    parameter logic signed [15:0] S_NP      = -16'sd4096,
    parameter logic signed [15:0] S_PN      = 16'sd4096,
    parameter logic signed [15:0] S_PP      = 16'sd16384,
    parameter logic signed [15:0] DEFAULT_Y = 16'sd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] w_nn,
    input  logic [15:0] w_np,
    input  logic [15:0] w_pn,
    input  logic [15:0] w_pp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y,
    output logic        zero_w
);

    typedef enum logic [2:0] {IDLE, MAC, DIV, FIX, DONE} state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [15:0]         r_wt [0:3];
    logic [1:0]          r_idx;
    logic signed [34:0]  r_num;
    logic [17:0]         r_den;
    logic [34:0]         r_quo;
    logic [17:0]         r_rem;
    logic [5:0]          r_cnt;
    logic [15:0]         r_y;
    logic                r_zero;
    logic                r_out_valid;

    // MAC datapath: one rule per cycle through the shared multiplier
    logic [15:0]         w_wsel;
    logic signed [15:0]  w_ssel;
    logic signed [32:0]  w_prod;
    logic signed [34:0]  w_num_nx;
    logic [17:0]         w_den_nx;
    logic [34:0]         w_num_abs;

    always_comb begin
        w_wsel = r_wt[r_idx];
        case (r_idx)
            2'd0:    w_ssel = S_NN;
            2'd1:    w_ssel = S_NP;
            2'd2:    w_ssel = S_PN;
            default: w_ssel = S_PP;
        endcase
    end

    assign w_prod    = $signed({1'b0, w_wsel}) * w_ssel;
    assign w_num_nx  = r_num + {{2{w_prod[32]}}, w_prod};
    assign w_den_nx  = r_den + {2'b00, w_wsel};
    assign w_num_abs = w_num_nx[34] ? 35'(-w_num_nx) : 35'(w_num_nx);

    // Restoring divider: r_quo shifts the dividend out MSB-first and the quotient in
    logic [18:0]         w_rem_sh;
    logic [18:0]         w_rem_diff;
    logic                w_qbit;
    logic [17:0]         w_rem_nx;

    assign w_rem_sh   = {r_rem, r_quo[34]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_den};
    assign w_qbit     = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_nx   = w_qbit ? w_rem_diff[17:0] : w_rem_sh[17:0];

    // Final sign, rounding and saturation
    logic                w_rnd;
    logic signed [35:0]  w_mag;
    logic signed [35:0]  w_sgn;
    logic [15:0]         w_y_fix;

`ifdef DEFUZZ_ROUND_EN
    assign w_rnd = ({r_rem, 1'b0} >= {1'b0, r_den});
`else
    assign w_rnd = 1'b0;
`endif

    assign w_mag = $signed({1'b0, r_quo}) + $signed({35'd0, w_rnd});
    assign w_sgn = r_num[34] ? -w_mag : w_mag;

    always_comb begin
        if (w_sgn > 36'sd32767)
            w_y_fix = 16'h7FFF;
        else if (w_sgn < -36'sd32768)
            w_y_fix = 16'h8000;
        else
            w_y_fix = w_sgn[15:0];
    end

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: if (in_valid)        w_state_nx = MAC;
            MAC:  if (r_idx == 2'd3)   w_state_nx = (w_den_nx == 18'd0) ? FIX : DIV;
            DIV:  if (r_cnt == 6'd34)  w_state_nx = FIX;
            FIX:                       w_state_nx = DONE;
            DONE: if (out_ready)       w_state_nx = IDLE;
            default:                   w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_wt[i] <= '0;
            r_idx       <= '0;
            r_num       <= '0;
            r_den       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_wt[0] <= w_nn;
                        r_wt[1] <= w_np;
                        r_wt[2] <= w_pn;
                        r_wt[3] <= w_pp;
                        r_num   <= '0;
                        r_den   <= '0;
                        r_idx   <= '0;
                    end
                end
                MAC: begin
                    r_num <= w_num_nx;
                    r_den <= w_den_nx;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_quo <= w_num_abs;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= {r_quo[33:0], w_qbit};
                    r_cnt <= r_cnt + 6'd1;
                end
                FIX: begin
                    if (r_den == 18'd0) begin
                        r_y    <= DEFAULT_Y;
                        r_zero <= 1'b1;
                    end else begin
                        r_y    <= w_y_fix;
                        r_zero <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign zero_w    = r_zero;

endmodule

// File: tb/tb_defuzz_wavg.sv
// Directed, table-driven bench for defuzz_wavg with backpressure and mid-division reset sequences.
module tb_defuzz_wavg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] w_nn, w_np, w_pn, w_pp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        zero_w;

    int n_chk  = 0;
    int n_fail = 0;

    defuzz_wavg dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .w_nn(w_nn), .w_np(w_np), .w_pn(w_pn), .w_pp(w_pp),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero_w(zero_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] nn, np, pn, pp;
        int          ey;
        logic        ez;
        int          elat;
    } vec_t;

`ifdef DEFUZZ_ROUND_EN
    localparam int Y_ODD = -2731;
`else
    localparam int Y_ODD = -2730;
`endif

    vec_t vecs [6];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present one weight set, return cycles from the capture edge to out_valid.
    task automatic send(input logic [15:0] a, b, c, d, output int lat);
        @(negedge clk);
        check("in_ready before send", in_ready, 1);
        in_valid = 1'b1;
        w_nn = a; w_np = b; w_pn = c; w_pp = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w_nn = 16'hDEAD; w_np = 16'hBEEF; w_pn = 16'h1234; w_pp = 16'h5678;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " out_valid drop"}, out_valid, 0);
        check({name, " in_ready back"}, in_ready, 1);
    endtask

    task automatic apply(input vec_t v);
        int lat;
        send(v.nn, v.np, v.pn, v.pp, lat);
        check({v.name, " latency"}, lat, v.elat);
        check({v.name, " y"}, $signed(y), v.ey);
        check({v.name, " zero_w"}, zero_w, v.ez);
        handshake(v.name);
    endtask

    initial begin
        int lat;
        vecs[0] = '{"pp_half",  16'h0000, 16'h0000, 16'h0000, 16'h8000, 16384, 1'b0, 40};
        vecs[1] = '{"nn_pp",    16'h4000, 16'h0000, 16'h0000, 16'h4000, 0,     1'b0, 40};
        vecs[2] = '{"nn_np",    16'h1000, 16'h3000, 16'h0000, 16'h0000, -7168, 1'b0, 40};
        vecs[3] = '{"all_zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0,     1'b1, 5};
        vecs[4] = '{"odd_neg",  16'h0001, 16'h0000, 16'h0002, 16'h0000, Y_ODD, 1'b0, 40};
        vecs[5] = '{"odd_pos",  16'h0000, 16'h0001, 16'h0000, 16'h0002, 9557,  1'b0, 40};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        w_nn = '0; w_np = '0; w_pn = '0; w_pp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset y", y, 0);
        check("reset zero_w", zero_w, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", in_ready, 1);

        for (int i = 0; i < 6; i++) apply(vecs[i]);

        // Backpressure: result held, busy, new requests ignored
        send(16'h0000, 16'h0000, 16'h0000, 16'h8000, lat);
        check("bp latency", lat, 40);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            w_nn = 16'h1000; w_np = 16'h3000; w_pn = 16'h0000; w_pp = 16'h0000;
            @(posedge clk); #1;
            check("bp y held", $signed(y), 16384);
            check("bp out_valid held", out_valid, 1);
            check("bp in_ready low", in_ready, 0);
        end
        @(negedge clk); in_valid = 1'b0;
        handshake("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp no spurious start", in_ready, 1);

        // Reset in the middle of the division
        @(negedge clk);
        in_valid = 1'b1;
        w_nn = 16'h0000; w_np = 16'h0000; w_pn = 16'h0000; w_pp = 16'h8000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("mid-div busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst y", y, 0);
        check("rst in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        check("no result after abort", lat, 0);
        check("rst idle in_ready", in_ready, 1);
        apply(vecs[2]);
        apply(vecs[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
